mpsoc_apb_arbiter: RTL

Shares one APB slave, such as the GPIO peripheral, between `MASTERS` APB masters, such as the AHB3 and Wishbone peripheral bridges. It arbitrates round-robin and registers the winning command. It then runs a single APB transfer on the slave side and returns the registered response to the winning master only. Non-granted masters are held in their access phase with `PREADY` low until they are served.

---
 rtl/mpsoc_apb_arbiter_pkg.sv | 15 +
 rtl/mpsoc_rr_arbiter.sv | 33 +++
 rtl/mpsoc_apb_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mpsoc_apb_arbiter_pkg.sv
// rtl/mpsoc_apb_arbiter_pkg.sv - shared types and helpers for the APB arbiter
package mpsoc_apb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mpsoc_rr_arbiter.sv
// rtl/mpsoc_rr_arbiter.sv - combinational round-robin picker
// Search starts one past last_grant_i and wraps, so every requester is reached within N picks.
module mpsoc_rr_arbiter
  import mpsoc_apb_arbiter_pkg::*;
#(
  parameter int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last_grant_i) + i) % N);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        grant_o[cand]  = 1'b1;
        grant_idx_o    = cand;
      end
    end
  end

endmodule

// File: rtl/mpsoc_apb_arbiter.sv
// rtl/mpsoc_apb_arbiter.sv - shares one APB slave between several APB masters
// Round-robin grant, registered command, single slave transfer, response to the winner only.
module mpsoc_apb_arbiter
  import mpsoc_apb_arbiter_pkg::*;
#(
  parameter int MASTERS    = 2,
  parameter int PADDR_SIZE = 10,
  parameter int PDATA_SIZE = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESET,

  input  logic                    m_PSEL    [MASTERS],
  input  logic                    m_PENABLE [MASTERS],
  input  logic                    m_PWRITE  [MASTERS],
  input  logic [PDATA_SIZE/8-1:0] m_PSTRB   [MASTERS],
  input  logic [PADDR_SIZE-1:0]   m_PADDR   [MASTERS],
  input  logic [PDATA_SIZE-1:0]   m_PWDATA  [MASTERS],
  output logic [PDATA_SIZE-1:0]   m_PRDATA  [MASTERS],
  output logic                    m_PREADY  [MASTERS],
  output logic                    m_PSLVERR [MASTERS],

  output logic                    s_PSEL,
  output logic                    s_PENABLE,
  output logic                    s_PWRITE,
  output logic [PDATA_SIZE/8-1:0] s_PSTRB,
  output logic [PADDR_SIZE-1:0]   s_PADDR,
  output logic [PDATA_SIZE-1:0]   s_PWDATA,
  input  logic [PDATA_SIZE-1:0]   s_PRDATA,
  input  logic                    s_PREADY,
  input  logic                    s_PSLVERR
);

  localparam int IW = idx_width(MASTERS);
  localparam int SW = PDATA_SIZE / 8;

  state_t                state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         last_grant_q, last_grant_d;
  logic                  pwrite_q, pwrite_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic [PADDR_SIZE-1:0] paddr_q, paddr_d;
  logic [PDATA_SIZE-1:0] pwdata_q, pwdata_d;
  logic [PDATA_SIZE-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;

  logic [MASTERS-1:0]    req;
  logic [MASTERS-1:0]    win_oh;
  logic [IW-1:0]         win_idx;
  logic                  win_pwrite;
  logic [SW-1:0]         win_pstrb;
  logic [PADDR_SIZE-1:0] win_paddr;
  logic [PDATA_SIZE-1:0] win_pwdata;
  logic                  gnt_penable;

  always_comb begin
    req = '0;
    for (int i = 0; i < MASTERS; i++) begin
      req[i] = m_PSEL[i];
    end
  end

  mpsoc_rr_arbiter #(
    .N (MASTERS)
  ) u_rr (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (win_oh),
    .grant_idx_o  (win_idx)
  );

  // One-hot AND-OR select of the winning master's command.
  always_comb begin
    win_pwrite = 1'b0;
    win_pstrb  = '0;
    win_paddr  = '0;
    win_pwdata = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (win_oh[i]) begin
        win_pwrite = win_pwrite | m_PWRITE[i];
        win_pstrb  = win_pstrb  | m_PSTRB[i];
        win_paddr  = win_paddr  | m_PADDR[i];
        win_pwdata = win_pwdata | m_PWDATA[i];
      end
    end
  end

  assign gnt_penable = m_PENABLE[grant_q];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pwrite_d     = pwrite_q;
    pstrb_d      = pstrb_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    prdata_d     = prdata_q;
    pslverr_d    = pslverr_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d  = win_idx;
          pwrite_d = win_pwrite;
          pstrb_d  = win_pstrb;
          paddr_d  = win_paddr;
          pwdata_d = win_pwdata;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (s_PREADY) begin
          prdata_d  = s_PRDATA;
          pslverr_d = s_PSLVERR;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        // Waits for the winner's access phase so PREADY is never lost.
        if (gnt_penable) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(MASTERS - 1);
      pwrite_q     <= 1'b0;
      pstrb_q      <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pwrite_q     <= pwrite_d;
      pstrb_q      <= pstrb_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      prdata_q     <= prdata_d;
      pslverr_q    <= pslverr_d;
    end
  end

  assign s_PSEL    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign s_PENABLE = (state_q == ST_ACCESS);
  assign s_PWRITE  = pwrite_q;
  assign s_PSTRB   = pstrb_q;
  assign s_PADDR   = paddr_q;
  assign s_PWDATA  = pwdata_q;

  always_comb begin
    for (int i = 0; i < MASTERS; i++) begin
      m_PRDATA[i]  = '0;
      m_PSLVERR[i] = 1'b0;
      m_PREADY[i]  = 1'b0;
      if ((state_q == ST_RESP) && (grant_q == IW'(i))) begin
        m_PRDATA[i]  = prdata_q;
        m_PSLVERR[i] = pslverr_q;
        m_PREADY[i]  = m_PENABLE[i];
      end
    end
  end

endmodule
